// File: rtl/des_pkg.sv
// Shared block/byte types for the UART -> DES -> TX datapath.
// Also carries the small state enums used by the block assembler.
package des_pkg;
  localparam int BLOCK_BYTES = 8;
  localparam int BLOCK_W     = 8 * BLOCK_BYTES;

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [7:0]         byte_t;

  typedef enum logic {ACC_IDLE, ACC_FILL}  acc_state_t;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;
endpackage

// File: rtl/idle_timer.sv
// Idle counter with clear, enable and a terminal-count flag.
// o_tc is high during the cycle the count sits at TIMEOUT_CYCLES-1.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_tc = i_en && w_last;
endmodule

// File: rtl/rx_block_assembler.sv
// Packs UART bytes into blocks, double-buffered toward the DES stage.
// Stalled partial blocks are dropped after an idle timeout.
module rx_block_assembler #(
  parameter int BLOCK_BYTES    = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_byte,
  output logic [8*BLOCK_BYTES-1:0]       blk_data,
  output logic                           blk_valid,
  input  logic                           blk_ready,
  output logic [$clog2(BLOCK_BYTES)-1:0] byte_count,
  output logic                           timeout,
  output logic                           overflow
);
  import des_pkg::*;

  localparam int W  = 8 * BLOCK_BYTES;
  localparam int CW = $clog2(BLOCK_BYTES);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_BYTES - 1);

  acc_state_t     r_acc_st;
  out_state_t     r_out_st;
  logic           r_prev_valid;
  logic [W-1:0]   r_acc;
  logic [CW-1:0]  r_count;
  logic [W-1:0]   r_blk;
  logic           r_timeout;
  logic           r_overflow;

  byte_t          w_byte;
  logic           w_cap;
  logic           w_done;
  logic           w_hs;
  logic           w_tc;
  logic           w_expire;
  logic [W-1:0]   w_next;

  assign w_byte   = rx_byte;
  assign w_cap    = rx_valid && !r_prev_valid;
  assign w_done   = w_cap && (r_count == LAST);
  assign w_next   = {r_acc[W-9:0], w_byte};
  assign w_hs     = (r_out_st == OUT_FULL) && blk_ready;
  assign w_expire = w_tc && !w_cap;

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_cap || w_expire),
    .i_en  (r_acc_st == ACC_FILL),
    .o_tc  (w_tc)
  );

  // Resets high so a strobe already up at reset release is ignored.
  always_ff @(posedge clk) begin
    if (rst) r_prev_valid <= 1'b1;
    else     r_prev_valid <= rx_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_st  <= ACC_IDLE;
      r_acc     <= '0;
      r_count   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_acc_st)
        ACC_IDLE: begin
          if (w_cap) begin
            r_acc    <= w_next;
            r_count  <= r_count + CW'(1);
            r_acc_st <= ACC_FILL;
          end
        end
        ACC_FILL: begin
          if (w_cap) begin
            r_acc <= w_next;
            if (w_done) begin
              r_count  <= '0;
              r_acc_st <= ACC_IDLE;
            end else begin
              r_count  <= r_count + CW'(1);
            end
          end else if (w_expire) begin
            r_acc     <= '0;
            r_count   <= '0;
            r_acc_st  <= ACC_IDLE;
            r_timeout <= 1'b1;
          end
        end
      endcase
    end
  end

  // A completion while full and unaccepted is dropped, old block kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_st   <= OUT_EMPTY;
      r_blk      <= '0;
      r_overflow <= 1'b0;
    end else begin
      unique case (r_out_st)
        OUT_EMPTY: begin
          if (w_done) begin
            r_blk    <= w_next;
            r_out_st <= OUT_FULL;
          end
        end
        OUT_FULL: begin
          if (w_done && w_hs) begin
            r_blk <= w_next;
          end else if (w_done) begin
            r_overflow <= 1'b1;
          end else if (w_hs) begin
            r_out_st <= OUT_EMPTY;
          end
        end
      endcase
    end
  end

  assign blk_data   = r_blk;
  assign blk_valid  = (r_out_st == OUT_FULL);
  assign byte_count = r_count;
  assign timeout    = r_timeout;
  assign overflow   = r_overflow;
endmodule

// File: tb/tb_rx_block_assembler.sv
// Scoreboard bench for rx_block_assembler with a queue-based model.
// Directed scenarios followed by randomized traffic and backpressure.
module tb_rx_block_assembler;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic [63:0] blk_data;
  logic        blk_valid;
  logic        blk_ready;
  logic [2:0]  byte_count;
  logic        timeout;
  logic        overflow;

  always #5 clk = ~clk;

  rx_block_assembler #(
    .BLOCK_BYTES(8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .blk_data   (blk_data),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .byte_count (byte_count),
    .timeout    (timeout),
    .overflow   (overflow)
  );

  int checks = 0;
  int errors = 0;

  bit mon_en = 1'b0;
  bit rnd_ready = 1'b0;

  logic [7:0]  m_bytes[$];
  logic [63:0] exp_q[$];
  bit          m_prev = 1'b1;
  bit          m_full = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_to = 1'b0;
  int          m_idle = 0;

  int          n_accept = 0;
  int          n_to = 0;
  logic [63:0] last_acc = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a byte list that becomes a block at 8 entries, a
  // one-deep output slot, and an idle counter while bytes are pending.
  always @(posedge clk) begin
    bit          cap;
    bit          done;
    bit          hs;
    logic [63:0] b;
    cap  = 1'b0;
    done = 1'b0;
    hs   = 1'b0;
    b    = '0;
    if (rst) begin
      m_bytes.delete();
      exp_q.delete();
      m_prev = 1'b1;
      m_full = 1'b0;
      m_ovf  = 1'b0;
      m_to   = 1'b0;
      m_idle = 0;
    end else begin
      cap    = rx_valid && !m_prev;
      m_prev = rx_valid;
      m_to   = 1'b0;
      hs     = m_full && blk_ready;
      if (cap) begin
        m_bytes.push_back(rx_byte);
        m_idle = 0;
        if (m_bytes.size() == 8) begin
          foreach (m_bytes[i]) b = (b << 8) | 64'(m_bytes[i]);
          m_bytes.delete();
          done = 1'b1;
        end
      end else if (m_bytes.size() != 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_bytes.delete();
          m_idle = 0;
          m_to   = 1'b1;
        end
      end
      if (done) begin
        if (!m_full || hs) begin
          exp_q.push_back(b);
          m_full = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (hs) begin
        m_full = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("blk_valid", 64'(blk_valid), 64'(m_full));
      chk("byte_count", 64'(byte_count), 64'(m_bytes.size()));
      chk("timeout", 64'(timeout), 64'(m_to));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (timeout) n_to++;
      if (blk_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL blk_data: got %0h expected no block", blk_data);
        end else begin
          chk("blk_data", blk_data, exp_q[0]);
          if (blk_ready) begin
            last_acc = blk_data;
            n_accept++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) blk_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int hold, input int gap);
    rx_byte  = b;
    rx_valid = 1'b1;
    cyc(hold);
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
    cyc(gap);
  endtask

  task automatic send_block(input logic [7:0] first, input int hold);
    for (int i = 0; i < 8; i++) send(8'(first + 8'(i)), hold, 1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    int n0;
    int hold;
    int gap;
    rst       = 1'b1;
    rx_valid  = 1'b1;
    rx_byte   = 8'h55;
    blk_ready = 1'b1;
    cyc(1);
    mon_en = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(3);
    chk("reset_held_strobe", 64'(byte_count), 64'd0);
    rx_valid = 1'b0;
    cyc(2);

    n0 = n_accept;
    send_block(8'h01, 1);
    cyc(3);
    chk("t1_accepts", 64'(n_accept - n0), 64'd1);
    chk("t1_data", last_acc, 64'h0102030405060708);

    n0 = n_accept;
    send_block(8'hA0, 5);
    cyc(3);
    chk("t2_accepts", 64'(n_accept - n0), 64'd1);
    chk("t2_data", last_acc, 64'hA0A1A2A3A4A5A6A7);

    n0 = n_to;
    send(8'h11, 1, 1);
    send(8'h22, 1, 1);
    send(8'h33, 1, 1);
    cyc(TO + 5);
    chk("t3_timeouts", 64'(n_to - n0), 64'd1);
    chk("t3_count", 64'(byte_count), 64'd0);
    send_block(8'h01, 1);
    cyc(3);
    chk("t3_data", last_acc, 64'h0102030405060708);

    blk_ready = 1'b0;
    send_block(8'h01, 1);
    send_block(8'h09, 1);
    cyc(2);
    chk("t4_hold", blk_data, 64'h0102030405060708);
    chk("t4_ovf", 64'(overflow), 64'd1);
    n0 = n_accept;
    blk_ready = 1'b1;
    cyc(2);
    chk("t4_accepts", 64'(n_accept - n0), 64'd1);
    chk("t4_valid", 64'(blk_valid), 64'd0);
    chk("t4_ovf_sticky", 64'(overflow), 64'd1);

    pulse_rst();
    cyc(1);
    blk_ready = 1'b0;
    send_block(8'h21, 1);
    for (int i = 0; i < 7; i++) send(8'(8'h31 + 8'(i)), 1, 1);
    n0 = n_accept;
    rx_byte   = 8'h38;
    rx_valid  = 1'b1;
    blk_ready = 1'b1;
    cyc(1);
    rx_valid  = 1'b0;
    blk_ready = 1'b0;
    cyc(2);
    chk("t5_accepts", 64'(n_accept - n0), 64'd1);
    chk("t5_acc_data", last_acc, 64'h2122232425262728);
    chk("t5_valid", 64'(blk_valid), 64'd1);
    chk("t5_data", blk_data, 64'h3132333435363738);
    chk("t5_ovf", 64'(overflow), 64'd0);

    send_block(8'h01, 1);
    send_block(8'h09, 1);
    for (int i = 0; i < 4; i++) send(8'(8'h41 + 8'(i)), 1, 1);
    pulse_rst();
    chk("t6_valid", 64'(blk_valid), 64'd0);
    chk("t6_count", 64'(byte_count), 64'd0);
    chk("t6_ovf", 64'(overflow), 64'd0);
    blk_ready = 1'b1;
    cyc(1);
    send_block(8'h01, 1);
    cyc(3);
    chk("t6_data", last_acc, 64'h0102030405060708);

    rnd_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      hold = $urandom_range(1, 3);
      gap  = ($urandom_range(0, 11) == 0) ? TO + 10 : $urandom_range(1, 4);
      send(8'($urandom), hold, gap);
    end
    rnd_ready = 1'b0;
    blk_ready = 1'b1;
    cyc(TO + 10);
    chk("drain", 64'(exp_q.size()), 64'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
